ram_port_scheduler: RTL and testbench

Single-clock controller that owns a simple dual-port block RAM and shares its read port among `NUM_READERS` requesters with round-robin arbitration. It also sequences the RAM: after every reset it zero-fills all locations before it admits any traffic. One external writer owns the write port once initialization completes. The block sits between shared-table clients (lookup tables, trace buffers) and the RAM primitive, so clients never drive the RAM directly.

---
 rtl/ram_port_scheduler_pkg.sv | 14 +
 rtl/ram_port_scheduler_rr_arbiter.sv | 36 +++
 rtl/sdp_block_ram_dc.sv | 30 +++
 rtl/ram_port_scheduler.sv | 132 +++++++++++++
 tb/tb_ram_port_scheduler.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_scheduler_pkg.sv
// Shared types and sizing helpers for the RAM port scheduler and its arbiter.
package ram_port_scheduler_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Pointer width for an N-entry round robin; a single requester still gets one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_port_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above the pointer wins, wrapping mod N.
module rr_arbiter
  import ram_port_scheduler_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] grant_idx_o,
  output logic          fired_o
);

  int           cand;
  logic [N-1:0] one_hot;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    fired_o     = 1'b0;
    cand        = 0;
    one_hot     = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= N) cand = cand - N;
      one_hot = N'(1) << cand;
      if (!fired_o && |(req_i & one_hot)) begin
        grant_o     = one_hot;
        grant_idx_o = PW'(cand);
        fired_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdp_block_ram_dc.sv
// Simple dual-port block RAM with independent write/read clocks and registered read data.
module sdp_block_ram_dc #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_write_clock,
  input  logic                  i_write_enable,
  input  logic [ADDR_WIDTH-1:0] i_write_address,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic                  i_read_clock,
  input  logic                  i_read_enable,
  input  logic [ADDR_WIDTH-1:0] i_read_address,
  output logic [DATA_WIDTH-1:0] o_read_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] read_data_q;

  always_ff @(posedge i_write_clock) begin
    if (i_write_enable) mem[i_write_address] <= i_write_data;
  end

  // Same-edge collisions return the old word since the read samples before the write lands.
  always_ff @(posedge i_read_clock) begin
    if (i_read_enable) read_data_q <= mem[i_read_address];
  end

  assign o_read_data = read_data_q;

endmodule

// File: rtl/ram_port_scheduler.sv
// Owns a simple dual-port RAM: zero-fills it after reset, then shares the read port
// round-robin among NUM_READERS requesters while one external writer owns the write port.
//
//   state | meaning
//   INIT  | writing 0 to the fill-counter address each cycle; all traffic refused
//   RUN   | writer always ready, reads granted round-robin with 1-cycle response
module ram_port_scheduler
  import ram_port_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_READERS = 4
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_write_valid,
  output logic                              o_write_ready,
  input  logic [ADDR_WIDTH-1:0]             i_write_address,
  input  logic [DATA_WIDTH-1:0]             i_write_data,
  input  logic [NUM_READERS-1:0]            i_read_valid,
  input  logic [NUM_READERS*ADDR_WIDTH-1:0] i_read_address,
  output logic [NUM_READERS-1:0]            o_read_ready,
  output logic [NUM_READERS-1:0]            o_response_valid,
  output logic [DATA_WIDTH-1:0]             o_response_data,
  output logic                              o_init_done
);

  localparam int PW = ptr_width(NUM_READERS);

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    fill_q, fill_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic [NUM_READERS-1:0]   resp_valid_q;

  logic [NUM_READERS-1:0]   arb_req;
  logic [NUM_READERS-1:0]   grant;
  logic [PW-1:0]            grant_idx;
  logic                     grant_fired;

  logic                     ram_we;
  logic [ADDR_WIDTH-1:0]    ram_waddr;
  logic [DATA_WIDTH-1:0]    ram_wdata;
  logic [ADDR_WIDTH-1:0]    ram_raddr;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= INIT;
      fill_q       <= '0;
      ptr_q        <= '0;
      resp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      ptr_q        <= ptr_d;
      resp_valid_q <= grant;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    case (state_q)
      INIT: begin
        fill_d = fill_q + 1'b1;
        if (fill_q == '1) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Requests are masked during INIT so no grant, ready or pointer move can leak out.
  assign arb_req = (state_q == RUN) ? i_read_valid : '0;

  rr_arbiter #(
    .N  (NUM_READERS),
    .PW (PW)
  ) u_rr_arbiter (
    .req_i       (arb_req),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .fired_o     (grant_fired)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (grant_fired) begin
      if (int'(grant_idx) == NUM_READERS - 1) ptr_d = '0;
      else                                    ptr_d = grant_idx + 1'b1;
    end
  end

  always_comb begin
    ram_raddr = '0;
    for (int k = 0; k < NUM_READERS; k++) begin
      if (grant[k]) ram_raddr = i_read_address[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    if (state_q == INIT) begin
      ram_we    = 1'b1;
      ram_waddr = fill_q;
      ram_wdata = '0;
    end else begin
      ram_we    = i_write_valid;
      ram_waddr = i_write_address;
      ram_wdata = i_write_data;
    end
  end

  sdp_block_ram_dc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .i_write_clock   (i_clock),
    .i_write_enable  (ram_we),
    .i_write_address (ram_waddr),
    .i_write_data    (ram_wdata),
    .i_read_clock    (i_clock),
    .i_read_enable   (grant_fired),
    .i_read_address  (ram_raddr),
    .o_read_data     (o_response_data)
  );

  assign o_init_done      = (state_q == RUN);
  assign o_write_ready    = (state_q == RUN);
  assign o_read_ready     = grant;
  assign o_response_valid = resp_valid_q;

endmodule

// File: tb/tb_ram_port_scheduler.sv
// Directed bench for ram_port_scheduler: init timing, arbitration order, collisions, async reset.
module tb_ram_port_scheduler;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 4;

  logic             i_clock;
  logic             i_reset;
  logic             i_write_valid;
  logic             o_write_ready;
  logic [AW-1:0]    i_write_address;
  logic [DW-1:0]    i_write_data;
  logic [NR-1:0]    i_read_valid;
  logic [NR*AW-1:0] i_read_address;
  logic [NR-1:0]    o_read_ready;
  logic [NR-1:0]    o_response_valid;
  logic [DW-1:0]    o_response_data;
  logic             o_init_done;

  int n_checks = 0;
  int n_fails  = 0;

  ram_port_scheduler #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .NUM_READERS (NR)
  ) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_write_valid    (i_write_valid),
    .o_write_ready    (o_write_ready),
    .i_write_address  (i_write_address),
    .i_write_data     (i_write_data),
    .i_read_valid     (i_read_valid),
    .i_read_address   (i_read_address),
    .o_read_ready     (o_read_ready),
    .o_response_valid (o_response_valid),
    .o_response_data  (o_response_data),
    .o_init_done      (o_init_done)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 ns after it.
  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic check_all_low(input string tag);
    check_eq({tag, "_done"},  64'(o_init_done),      64'd0);
    check_eq({tag, "_wrdy"},  64'(o_write_ready),    64'd0);
    check_eq({tag, "_rrdy"},  64'(o_read_ready),     64'd0);
    check_eq({tag, "_rvld"},  64'(o_response_valid), 64'd0);
  endtask

  // Counts edges from reset release until o_init_done; readers and writer stay busy throughout.
  task automatic wait_init(input string tag);
    int cnt;
    int rdy_seen;
    cnt = 0;
    rdy_seen = 0;
    i_read_valid  = '1;
    i_write_valid = 1'b1;
    while (!o_init_done && cnt < 100) begin
      if (o_read_ready != '0 || o_write_ready) rdy_seen++;
      step();
      cnt++;
    end
    i_read_valid  = '0;
    i_write_valid = 1'b0;
    check_eq({tag, "_cycles"}, 64'(cnt), 64'd32);
    check_eq({tag, "_rdy_in_init"}, 64'(rdy_seen), 64'd0);
  endtask

  task automatic do_read(input string tag, input int k, input logic [AW-1:0] addr,
                         input logic [DW-1:0] exp_data);
    i_read_valid = '0;
    i_read_valid[k] = 1'b1;
    i_read_address[k*AW +: AW] = addr;
    #1;
    check_eq({tag, "_grant"}, 64'(o_read_ready), 64'(4'b0001 << k));
    step();
    i_read_valid = '0;
    check_eq({tag, "_rvld"}, 64'(o_response_valid), 64'(4'b0001 << k));
    check_eq({tag, "_data"}, 64'(o_response_data), 64'(exp_data));
  endtask

  initial begin
    logic [3:0] exp_oh;
    logic [DW-1:0] exp_d;
    i_reset         = 1'b1;
    i_write_valid   = 1'b0;
    i_write_address = '0;
    i_write_data    = '0;
    i_read_valid    = '0;
    i_read_address  = '0;
    repeat (2) step();
    check_all_low("reset");
    i_reset = 1'b0;
    wait_init("init1");

    do_read("rd_a0",  0, 5'd0,  32'h0);
    do_read("rd_a17", 1, 5'd17, 32'h0);
    do_read("rd_a31", 2, 5'd31, 32'h0);

    i_write_valid   = 1'b1;
    i_write_address = 5'd3;
    i_write_data    = 32'hDEADBEEF;
    #1;
    check_eq("wr_ready", 64'(o_write_ready), 64'd1);
    step();
    i_write_valid = 1'b0;
    do_read("rd_after_wr", 2, 5'd3, 32'hDEADBEEF);
    do_read("rd_ptr_to0",  3, 5'd0, 32'h0);

    // Pointer is now 0; readers address 0, 17, 31, 3.
    i_read_address = {5'd3, 5'd31, 5'd17, 5'd0};
    i_read_valid   = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      exp_oh = 4'b0001 << (i % 4);
      exp_d  = ((i % 4) == 3) ? 32'hDEADBEEF : 32'h0;
      #1;
      check_eq($sformatf("rr_grant%0d", i), 64'(o_read_ready), 64'(exp_oh));
      step();
      check_eq($sformatf("rr_rvld%0d", i), 64'(o_response_valid), 64'(exp_oh));
      check_eq($sformatf("rr_data%0d", i), 64'(o_response_data), 64'(exp_d));
    end
    i_read_valid = '0;

    i_write_valid   = 1'b1;
    i_write_address = 5'd7;
    i_write_data    = 32'h1;
    i_read_valid    = 4'b0001;
    i_read_address[0 +: AW] = 5'd7;
    #1;
    check_eq("coll_grant", 64'(o_read_ready), 64'h1);
    step();
    i_write_valid = 1'b0;
    check_eq("coll_old_data", 64'(o_response_data), 64'h0);
    check_eq("coll_rvld", 64'(o_response_valid), 64'h1);
    step();
    i_read_valid = '0;
    check_eq("coll_new_data", 64'(o_response_data), 64'h1);

    do_read("rd_ptr_to2", 1, 5'd0, 32'h0);
    i_read_valid = 4'b1010;
    #1;
    check_eq("skip_grant3", 64'(o_read_ready), 64'b1000);
    step();
    check_eq("skip_rvld3",  64'(o_response_valid), 64'b1000);
    check_eq("skip_grant1", 64'(o_read_ready), 64'b0010);
    step();
    i_read_valid = '0;
    check_eq("skip_rvld1", 64'(o_response_valid), 64'b0010);

    // Reset mid-fill at counter 10.
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    repeat (10) step();
    #2;
    i_reset = 1'b1;
    #1;
    check_all_low("rst_fill");
    i_reset = 1'b0;
    wait_init("init2");

    // Reset while a response is pending.
    i_read_valid = 4'b0010;
    i_read_address[1*AW +: AW] = 5'd3;
    step();
    check_eq("pend_rvld", 64'(o_response_valid), 64'b0010);
    #2;
    i_reset = 1'b1;
    #1;
    check_all_low("rst_pend");
    i_read_valid = '0;
    i_reset = 1'b0;
    wait_init("init3");

    i_read_valid = 4'b1111;
    #1;
    check_eq("ptr_after_rst", 64'(o_read_ready), 64'b0001);
    i_read_valid = '0;
    do_read("fill_overwrote", 0, 5'd3, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
